// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch next-PC generator.
package fetch_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    // Tag is kept full-width; the bits above the real tag are always zero.
    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] tag;
        logic [PC_W-1:0] target;
    } btb_entry_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: async-reset valid bits, combinational
// lookup, synchronous write. A same-cycle write is visible from the next cycle.
module fetch_btb
    import fetch_pkg::*;
#(
    parameter int ENTRIES    = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] i_lkp_pc,
    output logic            o_hit,
    output logic [PC_W-1:0] o_target,
    input  logic            i_upd_valid,
    input  logic [PC_W-1:0] i_upd_pc,
    input  logic [PC_W-1:0] i_upd_target
);

    logic [ENTRIES-1:0] r_valid;
    logic [PC_W-1:0]    r_tag    [ENTRIES];
    logic [PC_W-1:0]    r_target [ENTRIES];

    logic [INDEX_BITS-1:0] w_lkp_idx;
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic [PC_W-1:0]       w_lkp_tag;
    logic [PC_W-1:0]       w_upd_tag;
    btb_entry_t            w_entry;

    assign w_lkp_idx = i_lkp_pc[INDEX_BITS+1:2];
    assign w_upd_idx = i_upd_pc[INDEX_BITS+1:2];
    assign w_lkp_tag = i_lkp_pc >> (INDEX_BITS + 2);
    assign w_upd_tag = i_upd_pc >> (INDEX_BITS + 2);

    always_comb begin
        w_entry        = '0;
        w_entry.valid  = r_valid[w_lkp_idx];
        w_entry.tag    = r_tag[w_lkp_idx];
        w_entry.target = r_target[w_lkp_idx];
    end

    assign o_hit    = w_entry.valid && (w_entry.tag == w_lkp_tag);
    assign o_target = w_entry.target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_upd_valid) begin
            r_valid[w_upd_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (i_upd_valid) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= word_align(i_upd_target);
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC register, BOOT/RUN/FLUSH request FSM and next-PC selection.
// The BTB is built only when FETCH_BTB_EN is defined; otherwise fetch is sequential.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int              BTB_ENTRIES = 16,
    parameter int              INDEX_BITS  = 4,
    parameter logic [PC_W-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] pc,
    input  logic            pred_taken,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic            fetch_pred_taken,
    output logic [PC_W-1:0] fetch_pred_target,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    output logic [1:0]      dbg_state
);

    logic [PC_W-1:0] r_pc;
    fetch_state_e    r_state;
    logic            r_fetch_valid;

    logic            w_hit;
    logic [PC_W-1:0] w_btb_target;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_pred_taken;

`ifdef FETCH_BTB_EN
    fetch_btb #(
        .ENTRIES    (BTB_ENTRIES),
        .INDEX_BITS (INDEX_BITS)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .i_lkp_pc     (r_pc),
        .o_hit        (w_hit),
        .o_target     (w_btb_target),
        .i_upd_valid  (upd_valid),
        .i_upd_pc     (upd_pc),
        .i_upd_target (upd_target)
    );
`else
    logic w_unused_btb;
    assign w_hit        = 1'b0;
    assign w_btb_target = '0;
    assign w_unused_btb = ^{pred_taken, upd_valid, upd_pc, upd_target};
`endif

    assign w_pc_inc     = r_pc + PC_INC;
    assign w_pred_taken = w_hit & pred_taken;

    assign pc                = r_pc;
    assign fetch_valid       = r_fetch_valid;
    assign fetch_pred_taken  = w_pred_taken;
    assign fetch_pred_target = w_pred_taken ? w_btb_target : w_pc_inc;
    assign dbg_state         = r_state;

    // Handshake: a request is offered while fetch_valid=1 and is consumed on
    // any edge where fetch_ready=1; until then pc and its outputs hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_state       <= ST_BOOT;
            r_fetch_valid <= 1'b0;
        end else if (redirect_valid) begin
            r_pc          <= word_align(redirect_pc);
            r_state       <= ST_FLUSH;
            r_fetch_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT, ST_FLUSH: begin
                    r_state       <= ST_RUN;
                    r_fetch_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (fetch_ready) begin
                        r_pc <= fetch_pred_target;
                    end
                end
                default: begin
                    r_state       <= ST_BOOT;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen; expectations follow FETCH_BTB_EN.
module tb_fetch_pc_gen;

`ifdef FETCH_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pred_taken;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        fetch_pred_taken;
    logic [31:0] fetch_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_pc_gen #(
        .BTB_ENTRIES (16),
        .INDEX_BITS  (4),
        .RESET_PC    (32'h0000_0100)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pc                (pc),
        .pred_taken        (pred_taken),
        .fetch_valid       (fetch_valid),
        .fetch_ready       (fetch_ready),
        .fetch_pred_taken  (fetch_pred_taken),
        .fetch_pred_target (fetch_pred_target),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .upd_valid         (upd_valid),
        .upd_pc            (upd_pc),
        .upd_target        (upd_target),
        .dbg_state         (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic [31:0] exp_pc, input logic exp_valid);
        chk({tag, ".pc"}, pc, exp_pc);
        chk({tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, exp_valid});
    endtask

    // Redirect, check the FLUSH bubble, end in the first valid cycle at the target.
    task automatic redirect_to(input string tag, input logic [31:0] a);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk_req({tag, ".flush"}, a & ~32'd3, 1'b0);
        chk({tag, ".flush_state"}, {30'd0, dbg_state}, 32'd2);
        @(negedge clk);
        #1;
        chk_req({tag, ".run"}, a & ~32'd3, 1'b1);
    endtask

    initial begin
        rst = 1'b1; pred_taken = 1'b0; fetch_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk_req("rst", 32'h100, 1'b0);
        chk("rst.pt", {31'd0, fetch_pred_taken}, 32'd0);
        chk("rst.tgt", fetch_pred_target, 32'h104);
        chk("rst.state", {30'd0, dbg_state}, 32'd0);

        // BOOT bubble then sequential fetch
        @(negedge clk); rst = 1'b0; #1;
        chk_req("boot", 32'h100, 1'b0);
        @(negedge clk); #1; chk_req("seq0", 32'h100, 1'b1);
        chk("seq0.state", {30'd0, dbg_state}, 32'd1);
        @(negedge clk); #1; chk_req("seq1", 32'h104, 1'b1);
        @(negedge clk); #1; chk_req("seq2", 32'h108, 1'b1);
        chk("seq2.tgt", fetch_pred_target, 32'h10C);

        // Install 0x108->0x200 together with a redirect to 0x104
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h108; upd_target = 32'h200;
        redirect_valid = 1'b1; redirect_pc = 32'h104;
        @(negedge clk);
        upd_valid = 1'b0; redirect_valid = 1'b0; #1;
        chk_req("upd.flush", 32'h104, 1'b0);
        @(negedge clk); #1; chk_req("upd.run", 32'h104, 1'b1);
        chk("upd.tgt104", fetch_pred_target, 32'h108);
        @(negedge clk); pred_taken = 1'b1; #1;
        chk_req("hit", 32'h108, 1'b1);
        chk("hit.pt", {31'd0, fetch_pred_taken}, {31'd0, BTB});
        chk("hit.tgt", fetch_pred_target, BTB ? 32'h200 : 32'h10C);
        @(negedge clk); pred_taken = 1'b0; #1;
        chk_req("hit.next", BTB ? 32'h200 : 32'h10C, 1'b1);

        // Hit but predicted not-taken
        redirect_to("nt", 32'h108);
        chk("nt.pt", {31'd0, fetch_pred_taken}, 32'd0);
        chk("nt.tgt", fetch_pred_target, 32'h10C);
        @(negedge clk); #1; chk_req("nt.next", 32'h10C, 1'b1);

        // Lookup and overwrite of the same index in one cycle sees old contents
        redirect_to("same", 32'h108);
        pred_taken = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h148; upd_target = 32'h301;
        #1;
        chk("same.pt", {31'd0, fetch_pred_taken}, {31'd0, BTB});
        chk("same.tgt", fetch_pred_target, BTB ? 32'h200 : 32'h10C);
        @(negedge clk); upd_valid = 1'b0; pred_taken = 1'b0; #1;
        chk_req("same.next", BTB ? 32'h200 : 32'h10C, 1'b1);

        // Alias: 0x148 replaced 0x108 at index 2
        redirect_to("alias108", 32'h108);
        pred_taken = 1'b1; #1;
        chk("alias108.pt", {31'd0, fetch_pred_taken}, 32'd0);
        chk("alias108.tgt", fetch_pred_target, 32'h10C);
        redirect_to("alias148", 32'h148);
        chk("alias148.pt", {31'd0, fetch_pred_taken}, {31'd0, BTB});
        chk("alias148.tgt", fetch_pred_target, BTB ? 32'h300 : 32'h14C);
        @(negedge clk); pred_taken = 1'b0; #1;
        chk_req("alias148.next", BTB ? 32'h300 : 32'h14C, 1'b1);

        // Stall at 0x104 for three cycles
        redirect_to("stall", 32'h104);
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk_req("stall.hold", 32'h104, 1'b1);
            chk("stall.tgt", fetch_pred_target, 32'h108);
        end
        fetch_ready = 1'b1;
        @(negedge clk); #1; chk_req("stall.release", 32'h108, 1'b1);

        // Redirect to 0x403 while stalled drops the request
        fetch_ready = 1'b0;
        @(negedge clk); #1; chk_req("rdst.hold", 32'h108, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'h403;
        @(negedge clk); redirect_valid = 1'b0; fetch_ready = 1'b1; #1;
        chk_req("rdst.flush", 32'h400, 1'b0);
        @(negedge clk); #1; chk_req("rdst.run0", 32'h400, 1'b1);
        @(negedge clk); #1; chk_req("rdst.run1", 32'h404, 1'b1);

        // PC+4 wraps at the top of the address space
        redirect_to("wrap", 32'hFFFF_FFFC);
        chk("wrap.tgt", fetch_pred_target, 32'h0);
        @(negedge clk); #1; chk_req("wrap.next", 32'h0, 1'b1);

        // Asynchronous reset during a stall
        fetch_ready = 1'b0;
        @(negedge clk); #1; chk_req("mrst.stall", 32'h0, 1'b1);
        rst = 1'b1; #1;
        chk_req("mrst", 32'h100, 1'b0);
        chk("mrst.state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk); rst = 1'b0; fetch_ready = 1'b1;
        @(negedge clk); #1; chk_req("mrst.run", 32'h100, 1'b1);

        // BTB contents are gone after reset
        pred_taken = 1'b1;
        redirect_to("clr", 32'h148);
        chk("clr.pt", {31'd0, fetch_pred_taken}, 32'd0);
        chk("clr.tgt", fetch_pred_target, 32'h14C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
